leaf_stream_mux: RTL and testbench
==================================

LEAF_STREAM_MUX -- requirements
Module: leaf_stream_mux

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, width of one stream word.
REQ-002 SHALL have parameter NUM_PORTS, default 4, number of user-side input streams (2..16).
REQ-003 SHALL have parameter NUM_PORT_BITS, default 2, tag width; ceil(log2(NUM_PORTS)).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, words per port FIFO; power of two, >=2.
REQ-005 SHALL have port clk_user  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port din_user2mux  in  NUM_PORTS*PAYLOAD_BITS  port i word at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 SHALL have port vld_user2mux  in  NUM_PORTS  per-port word valid.
REQ-009 SHALL have port ack_mux2user  out  NUM_PORTS  per-port word accepted.
REQ-010 SHALL have port dout_mux2interface  out  NUM_PORT_BITS+PAYLOAD_BITS  {source tag, payload}.
REQ-011 SHALL have port vld_mux2interface  out  1  output word valid.
REQ-012 SHALL have port ack_interface2mux  in  1  output word accepted.
REQ-013 SHALL have port fifo_full  out  NUM_PORTS  per-port FIFO full status.
REQ-014 SHALL have port stat_count  out  NUM_PORTS*16  per-port transfer counters (present only under LEAF_MUX_STATS_EN).

Function
REQ-015 SHALL treat a transfer as vld and ack both high in the same cycle, on every stream.
REQ-016 SHALL drive ack_mux2user[i] = not full[i] from registered occupancy, independent of vld and of same-cycle pops.
REQ-017 SHALL write din word i into FIFO i on each input transfer; a full FIFO SHALL NOT accept a word even if popped that cycle.
REQ-018 SHALL hold one output register with two states: EMPTY (vld low) and HOLD (vld high).
REQ-019 SHALL, in EMPTY or in HOLD with output transfer, load the output register from the round-robin-selected non-empty FIFO and pop it, same edge.
REQ-020 SHALL select round-robin starting at (last_grant+1) mod NUM_PORTS; last_grant updates only on load.
REQ-021 SHALL keep dout_mux2interface and vld_mux2interface stable in HOLD until ack_interface2mux.
REQ-022 SHALL go HOLD->EMPTY on output transfer only when all FIFOs are empty.
REQ-023 SHALL place the winning port index in tag bits [NUM_PORT_BITS+PAYLOAD_BITS-1 : PAYLOAD_BITS].
REQ-024 SHALL have latency: word accepted on edge k is valid at the output after edge k+1 if no other port wins.
REQ-025 SHALL sustain one output word per cycle while ack_interface2mux is held high and any FIFO is non-empty.
REQ-026 SHALL preserve per-port word order; pointers wrap modulo FIFO_DEPTH, occupancy 0..FIFO_DEPTH.
REQ-027 SHALL drive fifo_full[i] high exactly when occupancy[i] == FIFO_DEPTH.

Reset
REQ-028 SHALL, on reset_n low, immediately clear all FIFO pointers and occupancy, enter EMPTY, set last_grant to NUM_PORTS-1.
REQ-029 SHALL, during reset, drive vld_mux2interface 0, dout_mux2interface 0, fifo_full 0, ack_mux2user all 1s, stat_count 0.
REQ-030 SHALL, on reset mid-operation, discard all buffered and held words with no partial output.

Configuration
REQ-031 SHALL, with macro LEAF_MUX_STATS_EN defined, keep per-port 16-bit counters incrementing on each output transfer whose tag equals the port, saturating at 0xFFFF.
REQ-032 SHALL, without LEAF_MUX_STATS_EN, omit the stat_count port and counter logic entirely; all other behaviour identical.

Verification
REQ-033 SHALL cover single word: port 2 sends 0xDEADBEEF, ack held high -> output {2'd2,0xDEADBEEF} one cycle after the input edge.
REQ-034 SHALL cover fairness: all 4 ports continuously valid, ack high -> output tags 0,1,2,3,0,1,... with no port skipped.
REQ-035 SHALL cover backpressure: ack low, port 0 sends 6 words -> 1 held + 4 buffered, fifo_full[0]=1, ack_mux2user[0]=0; release -> 5 words in order, sixth accepted afterwards.
REQ-036 SHALL cover hold stability: ack low for 10 cycles with vld high -> dout unchanged all 10 cycles.
REQ-037 SHALL cover reset mid-stream: reset_n low with 3 words buffered -> vld low immediately; after release no stale word appears.
REQ-038 SHALL cover stats (LEAF_MUX_STATS_EN): 70000 transfers from port 1 -> stat_count[1]=0xFFFF, others 0.

Source files
------------

// File: rtl/leaf_stream_mux.sv
// Merges NUM_PORTS valid/ack word streams into one tagged stream via per-port FIFOs and a round-robin arbiter.
// Optional per-port transfer counters are built when LEAF_MUX_STATS_EN is defined.
module leaf_stream_mux #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_PORTS     = 4,
  parameter int NUM_PORT_BITS = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk_user,
  input  logic                                 reset_n,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0]    din_user2mux,
  input  logic [NUM_PORTS-1:0]                 vld_user2mux,
  output logic [NUM_PORTS-1:0]                 ack_mux2user,
  output logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0] dout_mux2interface,
  output logic                                 vld_mux2interface,
  input  logic                                 ack_interface2mux,
  output logic [NUM_PORTS-1:0]                 fifo_full
`ifdef LEAF_MUX_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]              stat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = NUM_PORT_BITS + 1;
  localparam logic [CW-1:0] NP_W = CW'(NUM_PORTS);

  typedef enum logic {S_EMPTY, S_HOLD} out_state_t;

  // Handshake: a word moves on any stream when its vld and ack are both high in
  // the same cycle; vld must then hold its word until that cycle occurs.
  logic [AW-1:0]           wr_ptr [NUM_PORTS];
  logic [AW-1:0]           rd_ptr [NUM_PORTS];
  logic [OW-1:0]           occ    [NUM_PORTS];
  logic [PAYLOAD_BITS-1:0] mem    [NUM_PORTS][FIFO_DEPTH];

  logic [NUM_PORTS-1:0]    full, nonempty, push, pop;
  out_state_t              out_state, out_state_nxt;
  logic [NUM_PORT_BITS-1:0] last_grant, grant_idx, cand_idx;
  logic [CW-1:0]           cand;
  logic                    grant_found, out_xfer, load_en, do_load;
  logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0] dout_q;
  logic [PAYLOAD_BITS-1:0] head;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]     = (occ[i] == OW'(FIFO_DEPTH));
      nonempty[i] = (occ[i] != '0);
      push[i]     = vld_user2mux[i] & ~full[i];
    end
  end

  assign ack_mux2user       = ~full;
  assign fifo_full          = full;
  assign vld_mux2interface  = (out_state == S_HOLD);
  assign dout_mux2interface = dout_q;

  // Search starts one past the last winner so every non-empty port is served within NUM_PORTS loads.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = {1'b0, last_grant} + CW'(off);
      if (cand >= NP_W) cand = cand - NP_W;
      cand_idx = cand[NUM_PORT_BITS-1:0];
      if (!grant_found && nonempty[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign out_xfer = (out_state == S_HOLD) && ack_interface2mux;
  assign load_en  = (out_state == S_EMPTY) || out_xfer;
  assign do_load  = load_en && grant_found;
  assign head     = mem[grant_idx][rd_ptr[grant_idx]];

  always_comb begin
    pop = '0;
    if (do_load) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    out_state_nxt = out_state;
    if (load_en) out_state_nxt = grant_found ? S_HOLD : S_EMPTY;
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      out_state  <= S_EMPTY;
      dout_q     <= '0;
      last_grant <= NUM_PORT_BITS'(NUM_PORTS - 1);
    end else begin
      out_state <= out_state_nxt;
      if (do_load) begin
        dout_q     <= {grant_idx, head};
        last_grant <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        occ[i] <= occ[i] + OW'(push[i]) - OW'(pop[i]);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_user) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din_user2mux[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

`ifdef LEAF_MUX_STATS_EN
  logic [15:0] cnt [NUM_PORTS];

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (out_xfer && (dout_q[PAYLOAD_BITS +: NUM_PORT_BITS] == NUM_PORT_BITS'(i))
            && (cnt[i] != 16'hFFFF))
          cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) stat_count[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_leaf_stream_mux.sv
// Directed bench for leaf_stream_mux: vector table for single-word latency/tagging,
// plus sequences for fairness, backpressure, hold stability, reset mid-stream and counters.
module tb_leaf_stream_mux;
  localparam int PB  = 32;
  localparam int NP  = 4;
  localparam int NPB = 2;
  localparam int FD  = 4;
  localparam int W   = NPB + PB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP*PB-1:0] din;
  logic [NP-1:0] vld, ack_user, fifo_full;
  logic [W-1:0]  dout;
  logic          vld_out, ack_if;
`ifdef LEAF_MUX_STATS_EN
  logic [NP*16-1:0] stat_count;
`endif

  leaf_stream_mux #(
    .PAYLOAD_BITS(PB), .NUM_PORTS(NP), .NUM_PORT_BITS(NPB), .FIFO_DEPTH(FD)
  ) dut (
    .clk_user(clk),
    .reset_n(rst_n),
    .din_user2mux(din),
    .vld_user2mux(vld),
    .ack_mux2user(ack_user),
    .dout_mux2interface(dout),
    .vld_mux2interface(vld_out),
    .ack_interface2mux(ack_if),
    .fifo_full(fifo_full)
`ifdef LEAF_MUX_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int           port;
    logic [PB-1:0] data;
    logic [W-1:0]  exp_dout;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int p, input logic [PB-1:0] w);
    din[p*PB +: PB] = w;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    vld    = '0;
    ack_if = 1'b0;
    #1;
    check("rst_vld", 64'(vld_out), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_ack", 64'(ack_user), 64'hF);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [PB-1:0] w;
    logic [W-1:0]  exp_w;
    int            got;
    logic          accepted;

    vecs[0] = '{port: 0, data: 32'h12345678, exp_dout: 34'h012345678};
    vecs[1] = '{port: 2, data: 32'hDEADBEEF, exp_dout: 34'h2DEADBEEF};
    vecs[2] = '{port: 3, data: 32'hFFFFFFFF, exp_dout: 34'h3FFFFFFFF};
    vecs[3] = '{port: 1, data: 32'h00000000, exp_dout: 34'h100000000};

    rst_n  = 1'b1;
    vld    = '0;
    ack_if = 1'b0;
    din    = '0;
    #2;
    do_reset();

    // single words: output valid one edge after the input edge, then drains
    ack_if = 1'b1;
    for (int v = 0; v < 4; v++) begin
      din = {NP{32'hA5A5A5A5}};
      set_lane(vecs[v].port, vecs[v].data);
      vld = '0;
      vld[vecs[v].port] = 1'b1;
      step();
      vld = '0;
      check("lat_early_vld", 64'(vld_out), 64'd0);
      step();
      check("lat_vld", 64'(vld_out), 64'd1);
      check("lat_dout", 64'(dout), 64'(vecs[v].exp_dout));
      step();
      check("lat_drain_vld", 64'(vld_out), 64'd0);
    end

    // fairness: all ports always valid, sink always ready
    do_reset();
    for (int p = 0; p < NP; p++) set_lane(p, 32'h10000000 + 32'(p));
    vld    = '1;
    ack_if = 1'b1;
    step();
    step();
    for (int c = 0; c < 8; c++) begin
      exp_w = {NPB'(c % 4), 32'h10000000 + 32'(c % 4)};
      check("rr_vld", 64'(vld_out), 64'd1);
      check("rr_dout", 64'(dout), 64'(exp_w));
      step();
    end
    vld    = '0;
    ack_if = 1'b0;

    // backpressure, hold stability and in-order release on port 0
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 5; n++) begin
      w = 32'hB0000000 + 32'(n);
      set_lane(0, w);
      vld[0] = 1'b1;
      check("bp_ack_open", 64'(ack_user[0]), 64'd1);
      exp_q.push_back({2'd0, w});
      step();
    end
    check("bp_full", 64'(fifo_full[0]), 64'd1);
    check("bp_ack_closed", 64'(ack_user[0]), 64'd0);
    check("bp_held_vld", 64'(vld_out), 64'd1);
    check("bp_held_dout", 64'(dout), 64'({2'd0, 32'hB0000000}));
    set_lane(0, 32'hB0000005);
    vld[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_vld", 64'(vld_out), 64'd1);
      check("hold_dout", 64'(dout), 64'({2'd0, 32'hB0000000}));
      check("hold_ack_closed", 64'(ack_user[0]), 64'd0);
    end
    ack_if = 1'b1;
    got    = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      accepted = vld[0] && ack_user[0];
      if (accepted) exp_q.push_back({2'd0, 32'hB0000005});
      if (vld_out) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected_word", 64'(dout), 64'd0 - 64'd1);
        end else begin
          check("bp_order", 64'(dout), 64'(exp_q.pop_front()));
        end
        got++;
      end
      step();
      if (accepted) vld[0] = 1'b0;
    end
    check("bp_words_out", 64'(got), 64'd6);
    check("bp_queue_left", 64'(exp_q.size()), 64'd0);
    vld    = '0;
    step();
    check("bp_drained_vld", 64'(vld_out), 64'd0);
    ack_if = 1'b0;

    // reset with one word held and three buffered on port 1
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_lane(1, 32'hC0000000 + 32'(n));
      vld[1] = 1'b1;
      step();
    end
    vld = '0;
    check("mid_vld_before", 64'(vld_out), 64'd1);
    check("mid_not_full", 64'(fifo_full[1]), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(vld_out), 64'd0);
    check("mid_rst_dout", 64'(dout), 64'd0);
    check("mid_rst_ack", 64'(ack_user), 64'hF);
    step();
    rst_n  = 1'b1;
    ack_if = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("mid_no_stale", 64'(vld_out), 64'd0);
    end
    set_lane(3, 32'h0000CAFE);
    vld[3] = 1'b1;
    step();
    vld = '0;
    step();
    check("mid_fresh_vld", 64'(vld_out), 64'd1);
    check("mid_fresh_dout", 64'(dout), 64'(34'h30000CAFE));
    step();
    ack_if = 1'b0;

`ifdef LEAF_MUX_STATS_EN
    do_reset();
    check("stat_rst", 64'(stat_count), 64'd0);
    set_lane(1, 32'h11111111);
    vld[1] = 1'b1;
    ack_if = 1'b1;
    for (int c = 0; c < 70010; c++) step();
    vld    = '0;
    ack_if = 1'b0;
    check("stat_p0", 64'(stat_count[15:0]), 64'd0);
    check("stat_p1_sat", 64'(stat_count[31:16]), 64'hFFFF);
    check("stat_p2", 64'(stat_count[47:32]), 64'd0);
    check("stat_p3", 64'(stat_count[63:48]), 64'd0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
